// File: rtl/uart_transmit.sv
// Buffered 8N1 UART transmitter: a small circular FIFO feeding an LSB-first
// serialiser with a registered, glitch-free serial output.
module uart_transmit #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DEPTH        = 4
) (
    input  logic                    i_CLK,
    input  logic                    i_RST,
    input  logic                    i_DataValid,
    input  logic [7:0]              i_Tx_Byte,
    output logic                    o_Full,
    output logic                    o_Empty,
    output logic [$clog2(DEPTH):0]  o_Count,
    output logic                    o_Tx_Serial,
    output logic                    o_Tx_Active,
    output logic                    o_Tx_Done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          push, pop;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          serial_q, serial_d;
    logic          done_q, done_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_Empty = (wr_ptr_q == rd_ptr_q);
    assign o_Full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign o_Count = wr_ptr_q - rd_ptr_q;
    assign push    = i_DataValid && !o_Full;

    assign o_Tx_Serial = serial_q;
    assign o_Tx_Active = (state_q != IDLE);
    assign o_Tx_Done   = done_q;

    always_ff @(posedge i_CLK) begin
        if (push && !i_RST) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_Tx_Byte;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!o_Empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q[AW-1:0]];
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decoded from the next state so the pin comes straight off a flop.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase

        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_uart_transmit.sv
// Bench for uart_transmit: a frame-timing reference model and a line decoder
// are compared against the DUT every cycle and per frame.
module tb_uart_transmit;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int CNTW  = $clog2(DEPTH) + 1;
    localparam logic [CNTW+4:0] IDLE_V = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, CNTW'(0)};

    logic            i_CLK = 1'b0;
    logic            i_RST = 1'b1;
    logic            i_DataValid = 1'b0;
    logic [7:0]      i_Tx_Byte = 8'h00;
    logic            o_Full, o_Empty, o_Tx_Serial, o_Tx_Active, o_Tx_Done;
    logic [CNTW-1:0] o_Count;

    int ncmp = 0;
    int nerr = 0;

    always #20 i_CLK = ~i_CLK;

    uart_transmit #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_DataValid(i_DataValid), .i_Tx_Byte(i_Tx_Byte),
        .o_Full(o_Full), .o_Empty(o_Empty), .o_Count(o_Count),
        .o_Tx_Serial(o_Tx_Serial), .o_Tx_Active(o_Tx_Active), .o_Tx_Done(o_Tx_Done)
    );

    wire [CNTW+4:0] obs = {o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Empty, o_Full, o_Count};

    // Reference model: a byte queue plus a frame timer; a frame occupies FRAME
    // cycles from its pop and the next pop may follow one idle cycle later.
    logic [7:0]      mq[$];
    logic [7:0]      sent_q[$];
    logic [7:0]      cur = 8'h00;
    int              timer = 0;
    bit              m_done = 1'b0;
    bit              m_acc, m_pop;
    logic [CNTW+4:0] expv;

    function automatic logic m_serial();
        int el, b;
        if (timer == 0) return 1'b1;
        el = FRAME - timer;
        b  = el / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return cur[b-1];
        return 1'b1;
    endfunction

    always @(posedge i_CLK) begin
        if (i_RST) begin
            mq.delete();
            timer  = 0;
            m_done = 1'b0;
        end else begin
            m_acc  = i_DataValid && (mq.size() < DEPTH);
            m_pop  = (timer == 0) && (mq.size() > 0);
            m_done = (timer == 1);
            if (timer > 0) timer--;
            if (m_pop) begin
                cur = mq.pop_front();
                sent_q.push_back(cur);
                timer = FRAME;
            end
            if (m_acc) mq.push_back(i_Tx_Byte);
        end
        expv = {m_serial(), timer > 0, m_done, mq.size() == 0, mq.size() == DEPTH, CNTW'(mq.size())};
    end

    // Line decoder: collects FRAME samples from the start bit, checks each bit
    // is held for CPB cycles with proper start/stop levels, and records the byte.
    logic       smp [FRAME];
    int         ns = 0;
    bit         in_fr = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] dbyte;
    bit         dok;
    int         bad_frames = 0;

    always @(negedge i_CLK) begin
        if (in_fr && !o_Tx_Active) begin
            in_fr = 1'b0;
        end else if (in_fr || (o_Tx_Active === 1'b1 && o_Tx_Serial === 1'b0)) begin
            if (!in_fr) ns = 0;
            in_fr = 1'b1;
            smp[ns] = o_Tx_Serial;
            ns++;
            if (ns == FRAME) begin
                in_fr = 1'b0;
                dok = 1'b1;
                for (int k = 0; k < 10; k++)
                    for (int j = 1; j < CPB; j++)
                        if (smp[k*CPB+j] !== smp[k*CPB]) dok = 1'b0;
                if (smp[0] !== 1'b0 || smp[9*CPB] !== 1'b1) dok = 1'b0;
                for (int k = 0; k < 8; k++) dbyte[k] = smp[(k+1)*CPB];
                if (!dok) bad_frames++;
                rx_q.push_back(dbyte);
            end
        end
    end

    task automatic test_reset();
        i_RST = 1'b1;
        i_DataValid = 1'b1;
        i_Tx_Byte = 8'hEE;
        repeat (3) begin
            @(negedge i_CLK);
            ncmp++;
            if (obs !== IDLE_V) begin nerr++; $display("FAIL reset_hold: got %b want %b", obs, IDLE_V); end
        end
        i_RST = 1'b0;
        i_DataValid = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge i_CLK);
            ncmp++;
            if (obs !== IDLE_V) begin nerr++; $display("FAIL reset_idle cyc %0d: got %b want %b", c, obs, IDLE_V); end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] line = '0;
        logic [9:0] exp_line = 10'b1101001010;
        int ndone = 0, done_at = -1, el;
        rx_q.delete();
        bad_frames = 0;
        i_DataValid = 1'b1;
        i_Tx_Byte = 8'hA5;
        @(negedge i_CLK);
        i_DataValid = 1'b0;
        ncmp++;
        if ({o_Tx_Serial, o_Count} !== {1'b1, CNTW'(1)}) begin
            nerr++; $display("FAIL single_write_edge: got ser/cnt %b want %b", {o_Tx_Serial, o_Count}, {1'b1, CNTW'(1)});
        end
        for (int c = 1; c <= FRAME + 4; c++) begin
            @(negedge i_CLK);
            ncmp++;
            if (obs !== expv) begin nerr++; $display("FAIL single_cycle %0d: got %b want %b", c, obs, expv); end
            el = c - 1;
            if (el < FRAME && (el % CPB) == CPB / 2) line[el/CPB] = o_Tx_Serial;
            if (o_Tx_Done) begin ndone++; done_at = c; end
        end
        ncmp++;
        if (line !== exp_line) begin nerr++; $display("FAIL single_line: got %b want %b", line, exp_line); end
        ncmp++;
        if (ndone != 1 || done_at != FRAME + 1) begin
            nerr++; $display("FAIL single_done: got %0d pulses at %0d want 1 at %0d", ndone, done_at, FRAME + 1);
        end
        ncmp++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || bad_frames != 0) begin
            nerr++; $display("FAIL single_rx: got %0d bytes (bad %0d) want 1 byte a5", rx_q.size(), bad_frames);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b[3] = '{8'h01, 8'h80, 8'hFF};
        int peak = 0, ndone = 0, starts[$];
        bit prev_act = 1'b0;
        rx_q.delete();
        bad_frames = 0;
        for (int c = 0; c < 3 * (FRAME + 1) + 6; c++) begin
            if (c < 3) begin i_DataValid = 1'b1; i_Tx_Byte = b[c]; end
            else i_DataValid = 1'b0;
            @(negedge i_CLK);
            ncmp++;
            if (obs !== expv) begin nerr++; $display("FAIL b2b_cycle %0d: got %b want %b", c, obs, expv); end
            if (int'(o_Count) > peak) peak = int'(o_Count);
            if (o_Tx_Done) ndone++;
            if (o_Tx_Active && !prev_act) starts.push_back(c);
            prev_act = o_Tx_Active;
        end
        ncmp++;
        if (peak != 2) begin nerr++; $display("FAIL b2b_peak: got %0d want 2", peak); end
        ncmp++;
        if (ndone != 3 || o_Empty !== 1'b1) begin
            nerr++; $display("FAIL b2b_done: got %0d pulses empty=%b want 3 pulses empty=1", ndone, o_Empty);
        end
        ncmp++;
        if (starts.size() != 3 || starts[1] - starts[0] != FRAME + 1 || starts[2] - starts[1] != FRAME + 1) begin
            nerr++; $display("FAIL b2b_gap: got %0d frames want 3 spaced %0d", starts.size(), FRAME + 1);
        end
        ncmp++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h80 || rx_q[2] !== 8'hFF || bad_frames != 0) begin
            nerr++; $display("FAIL b2b_rx: got %0d bytes (bad %0d) want 01 80 ff", rx_q.size(), bad_frames);
        end
    endtask

    task automatic test_overflow();
        bit rx_ok;
        rx_q.delete();
        bad_frames = 0;
        for (int c = 0; c < 5 * (FRAME + 1) + 6; c++) begin
            if (c < 6) begin i_DataValid = 1'b1; i_Tx_Byte = 8'h10 + 8'(c); end
            else i_DataValid = 1'b0;
            @(negedge i_CLK);
            ncmp++;
            if (obs !== expv) begin nerr++; $display("FAIL ovf_cycle %0d: got %b want %b", c, obs, expv); end
            if (c == 1) begin
                ncmp++;
                if ({o_Tx_Active, o_Tx_Serial} !== 2'b10) begin
                    nerr++; $display("FAIL ovf_first_pop: got act/ser %b want 10", {o_Tx_Active, o_Tx_Serial});
                end
            end
            if (c == 4 || c == 5) begin
                ncmp++;
                if ({o_Full, o_Count} !== {1'b1, CNTW'(4)}) begin
                    nerr++; $display("FAIL ovf_full cyc %0d: got full/cnt %b want %b", c, {o_Full, o_Count}, {1'b1, CNTW'(4)});
                end
            end
        end
        rx_ok = (rx_q.size() == 5) && (bad_frames == 0);
        for (int k = 0; k < 5 && rx_ok; k++) if (rx_q[k] !== 8'h10 + 8'(k)) rx_ok = 1'b0;
        ncmp++;
        if (!rx_ok) begin nerr++; $display("FAIL ovf_rx: got %0d bytes (bad %0d) want 10..14", rx_q.size(), bad_frames); end
    endtask

    task automatic test_reset_mid();
        rx_q.delete();
        bad_frames = 0;
        i_DataValid = 1'b1;
        i_Tx_Byte = 8'h3C;
        @(negedge i_CLK);
        i_DataValid = 1'b0;
        for (int c = 1; c <= 1 + 4 * CPB; c++) begin
            @(negedge i_CLK);
            ncmp++;
            if (obs !== expv) begin nerr++; $display("FAIL rstmid_cycle %0d: got %b want %b", c, obs, expv); end
        end
        i_RST = 1'b1;
        i_DataValid = 1'b1;
        i_Tx_Byte = 8'h99;
        @(negedge i_CLK);
        i_RST = 1'b0;
        i_DataValid = 1'b0;
        ncmp++;
        if ({o_Tx_Serial, o_Tx_Active, o_Empty} !== 3'b101) begin
            nerr++; $display("FAIL rstmid_after: got ser/act/empty %b want 101", {o_Tx_Serial, o_Tx_Active, o_Empty});
        end
        ncmp++;
        if (obs !== expv) begin nerr++; $display("FAIL rstmid_state: got %b want %b", obs, expv); end
        rx_q.delete();
        i_DataValid = 1'b1;
        i_Tx_Byte = 8'h55;
        @(negedge i_CLK);
        i_DataValid = 1'b0;
        for (int c = 1; c <= FRAME + 4; c++) begin
            @(negedge i_CLK);
            ncmp++;
            if (obs !== expv) begin nerr++; $display("FAIL rstmid_resend %0d: got %b want %b", c, obs, expv); end
        end
        ncmp++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55 || bad_frames != 0) begin
            nerr++; $display("FAIL rstmid_rx: got %0d bytes (bad %0d) want 1 byte 55", rx_q.size(), bad_frames);
        end
    endtask

    task automatic test_simul_write_pop();
        rx_q.delete();
        bad_frames = 0;
        for (int c = 0; c < 2 * (FRAME + 1) + 4; c++) begin
            if (c == 0) begin i_DataValid = 1'b1; i_Tx_Byte = 8'h42; end
            else if (c == 1) begin i_DataValid = 1'b1; i_Tx_Byte = 8'h77; end
            else i_DataValid = 1'b0;
            @(negedge i_CLK);
            ncmp++;
            if (obs !== expv) begin nerr++; $display("FAIL simul_cycle %0d: got %b want %b", c, obs, expv); end
            if (c == 1) begin
                ncmp++;
                if ({o_Tx_Active, o_Count} !== {1'b1, CNTW'(1)}) begin
                    nerr++; $display("FAIL simul_count: got act/cnt %b want %b", {o_Tx_Active, o_Count}, {1'b1, CNTW'(1)});
                end
            end
        end
        ncmp++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h42 || rx_q[1] !== 8'h77 || bad_frames != 0) begin
            nerr++; $display("FAIL simul_rx: got %0d bytes (bad %0d) want 42 77", rx_q.size(), bad_frames);
        end
    endtask

    task automatic test_random();
        int  guard = 0;
        bit  rx_ok;
        rx_q.delete();
        sent_q.delete();
        bad_frames = 0;
        for (int c = 0; c < 1500; c++) begin
            i_DataValid = ($urandom_range(0, 11) == 0);
            i_Tx_Byte   = 8'($urandom);
            @(negedge i_CLK);
            ncmp++;
            if (obs !== expv) begin nerr++; $display("FAIL random_cycle %0d: got %b want %b", c, obs, expv); end
        end
        i_DataValid = 1'b0;
        while ((mq.size() != 0 || timer != 0) && guard < 6 * (FRAME + 1)) begin
            @(negedge i_CLK);
            guard++;
            ncmp++;
            if (obs !== expv) begin nerr++; $display("FAIL random_drain %0d: got %b want %b", guard, obs, expv); end
        end
        ncmp++;
        if (mq.size() != 0 || timer != 0) begin
            nerr++; $display("FAIL random_timeout: got %0d queued want 0 after %0d cycles", mq.size(), guard);
        end
        repeat (2) @(negedge i_CLK);
        rx_ok = (rx_q.size() == sent_q.size()) && (bad_frames == 0) && (sent_q.size() > 0);
        for (int k = 0; k < rx_q.size() && rx_ok; k++) if (rx_q[k] !== sent_q[k]) rx_ok = 1'b0;
        ncmp++;
        if (!rx_ok) begin
            nerr++; $display("FAIL random_rx: got %0d bytes (bad %0d) want %0d matching", rx_q.size(), bad_frames, sent_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_simul_write_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
